// File: rtl/sparc_exu_regwb.sv
// rtl/sparc_exu_regwb.sv - E/M/W write-back pipe for per-thread register storage with kill, stall and thread tracking
// Optional operand bypass from the M and W entries is compiled in with EXU_REGWB_BYPASS_EN.
module sparc_exu_regwb #(
   parameter int SIZE = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            se,
   input  logic            wen_e,
   input  logic [3:0]      thr_e,
   input  logic [SIZE-1:0] data_e,
   input  logic            stall_m,
   input  logic            kill_m,
   input  logic            kill_w,
   input  logic [3:0]      thr_out,
   output logic            wen_w,
   output logic [3:0]      thr_w,
   output logic [SIZE-1:0] data_in_w,
   output logic [3:0]      pend,
   output logic            byp_hit,
   output logic [SIZE-1:0] byp_data,
   output logic            err_thr
);

   logic            m_valid_q, m_valid_d;
   logic [3:0]      m_thr_q, m_thr_d;
   logic [SIZE-1:0] m_data_q, m_data_d;
   logic            w_valid_q, w_valid_d;
   logic [3:0]      w_thr_q, w_thr_d;
   logic [SIZE-1:0] w_data_q, w_data_d;
   logic            err_thr_q, err_thr_d;
   logic            thr_onehot;

   assign thr_onehot = (thr_e != 4'b0000) && ((thr_e & (thr_e - 4'd1)) == 4'b0000);

   always_comb begin
      m_valid_d = m_valid_q;
      m_thr_d   = m_thr_q;
      m_data_d  = m_data_q;
      w_valid_d = w_valid_q;
      w_thr_d   = w_thr_q;
      w_data_d  = w_data_q;
      err_thr_d = err_thr_q;
      if (!stall_m) begin
         m_valid_d = wen_e & thr_onehot;
         m_thr_d   = thr_e;
         m_data_d  = data_e;
         w_valid_d = m_valid_q & ~kill_m;
         w_thr_d   = m_thr_q;
         w_data_d  = m_data_q;
         if (wen_e && !thr_onehot) begin
            err_thr_d = 1'b1;
         end
      end else begin
         // Upstream holds E during a stall, so only M can change (by kill); W gets a bubble.
         m_valid_d = m_valid_q & ~kill_m;
         w_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_thr_q   <= 4'b0000;
         m_data_q  <= '0;
         w_valid_q <= 1'b0;
         w_thr_q   <= 4'b0000;
         w_data_q  <= '0;
         err_thr_q <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         m_thr_q   <= m_thr_d;
         m_data_q  <= m_data_d;
         w_valid_q <= w_valid_d;
         w_thr_q   <= w_thr_d;
         w_data_q  <= w_data_d;
         err_thr_q <= err_thr_d;
      end
   end

   assign wen_w     = w_valid_q & ~kill_w;
   assign thr_w     = w_thr_q;
   assign data_in_w = w_data_q;
   assign err_thr   = err_thr_q;
   assign pend      = ({4{m_valid_q & ~kill_m}} & m_thr_q) |
                      ({4{w_valid_q & ~kill_w}} & w_thr_q);

`ifdef EXU_REGWB_BYPASS_EN
   logic m_hit, w_hit;
   logic unused_ok;

   assign m_hit     = m_valid_q & ~kill_m & (|(m_thr_q & thr_out));
   assign w_hit     = w_valid_q & ~kill_w & (|(w_thr_q & thr_out));
   // M holds the younger write, so it wins when both entries target the read thread.
   assign byp_hit   = m_hit | w_hit;
   assign byp_data  = m_hit ? m_data_q : (w_hit ? w_data_q : '0);
   assign unused_ok = se;
`else
   logic unused_ok;

   assign byp_hit   = 1'b0;
   assign byp_data  = '0;
   assign unused_ok = ^{se, thr_out};
`endif

endmodule

// File: tb/tb_sparc_exu_regwb.sv
// tb/tb_sparc_exu_regwb.sv - scoreboard bench for sparc_exu_regwb (bypass checks follow EXU_REGWB_BYPASS_EN)
module tb_sparc_exu_regwb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       se = 1'b0;
   logic       wen_e = 1'b0;
   logic [3:0] thr_e = 4'b0000;
   logic [2:0] data_e = 3'b000;
   logic       stall_m = 1'b0;
   logic       kill_m = 1'b0;
   logic       kill_w = 1'b0;
   logic [3:0] thr_out = 4'b0000;
   logic       wen_w;
   logic [3:0] thr_w;
   logic [2:0] data_in_w;
   logic [3:0] pend;
   logic       byp_hit;
   logic [2:0] byp_data;
   logic       err_thr;

   int tests = 0;
   int fails = 0;
   logic [6:0] exp_q[$];

   sparc_exu_regwb #(.SIZE(3)) dut (
      .clk(clk), .rst(rst), .se(se), .wen_e(wen_e), .thr_e(thr_e), .data_e(data_e),
      .stall_m(stall_m), .kill_m(kill_m), .kill_w(kill_w), .thr_out(thr_out),
      .wen_w(wen_w), .thr_w(thr_w), .data_in_w(data_in_w), .pend(pend),
      .byp_hit(byp_hit), .byp_data(byp_data), .err_thr(err_thr)
   );

   always #5 clk = ~clk;

   // Scoreboard: every committed write must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && wen_w) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: wen_w=1 thr_w=%b data=%b, required no write", thr_w, data_in_w);
         end else begin
            logic [6:0] e;
            e = exp_q.pop_front();
            if ({thr_w, data_in_w} !== e) begin
               fails++;
               $display("FAIL sb_data: got thr=%b data=%b, required thr=%b data=%b",
                        thr_w, data_in_w, e[6:3], e[2:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_e(input logic [3:0] t, input logic [2:0] d, input bit expect_commit);
      wen_e = 1'b1; thr_e = t; data_e = d;
      if (expect_commit) exp_q.push_back({t, d});
   endtask

   task automatic idle_e();
      wen_e = 1'b0; thr_e = 4'b0000; data_e = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      tests++;
      if ({wen_w, thr_w, data_in_w, pend, byp_hit, byp_data, err_thr} !== 17'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b, required all zero",
                  {wen_w, thr_w, data_in_w, pend, byp_hit, byp_data, err_thr});
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      write_e(4'b0100, 3'b101, 1);
      tick();
      idle_e();
      #1;
      tests++;
      if (pend !== 4'b0100 || wen_w !== 1'b0) begin
         fails++;
         $display("FAIL basic_m: pend=%b wen_w=%b, required pend=0100 wen_w=0", pend, wen_w);
      end
      tick();
      tests++;
      if (pend !== 4'b0100 || wen_w !== 1'b1 || thr_w !== 4'b0100 || data_in_w !== 3'b101) begin
         fails++;
         $display("FAIL basic_w: pend=%b wen_w=%b thr_w=%b data=%b, required 0100 1 0100 101",
                  pend, wen_w, thr_w, data_in_w);
      end
      tick();
      tests++;
      if (pend !== 4'b0000 || wen_w !== 1'b0) begin
         fails++;
         $display("FAIL basic_after: pend=%b wen_w=%b, required 0000 0", pend, wen_w);
      end
   endtask

   task automatic test_kill();
      write_e(4'b0001, 3'b011, 0);
      tick();
      idle_e();
      kill_m = 1'b1;
      #1;
      tests++;
      if (pend !== 4'b0000) begin
         fails++;
         $display("FAIL kill_m_pend: pend=%b, required 0000", pend);
      end
      tick();
      kill_m = 1'b0;
      #1;
      tests++;
      if (wen_w !== 1'b0) begin
         fails++;
         $display("FAIL kill_m_wen: wen_w=%b, required 0", wen_w);
      end
      write_e(4'b0001, 3'b010, 0);
      tick();
      idle_e();
      #1;
      tests++;
      if (pend !== 4'b0001) begin
         fails++;
         $display("FAIL kill_w_pend_m: pend=%b, required 0001", pend);
      end
      tick();
      kill_w = 1'b1;
      #1;
      tests++;
      if (wen_w !== 1'b0 || pend[0] !== 1'b0) begin
         fails++;
         $display("FAIL kill_w: wen_w=%b pend=%b, required wen_w=0 pend[0]=0", wen_w, pend);
      end
      tick();
      kill_w = 1'b0;
   endtask

   task automatic test_stall();
      write_e(4'b1000, 3'b111, 1);
      tick();
      idle_e();
      stall_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (wen_w !== 1'b0 || pend !== 4'b1000) begin
            fails++;
            $display("FAIL stall_hold%0d: wen_w=%b pend=%b, required 0 1000", i, wen_w, pend);
         end
      end
      stall_m = 1'b0;
      tick();
      tests++;
      if (wen_w !== 1'b1 || data_in_w !== 3'b111 || thr_w !== 4'b1000) begin
         fails++;
         $display("FAIL stall_release: wen_w=%b thr_w=%b data=%b, required 1 1000 111",
                  wen_w, thr_w, data_in_w);
      end
      tick();
   endtask

   task automatic test_bypass();
      thr_out = 4'b0010;
      write_e(4'b0010, 3'b001, 1);
      tick();
      write_e(4'b0010, 3'b110, 1);
      tick();
      idle_e();
      #1;
      tests++;
`ifdef EXU_REGWB_BYPASS_EN
      if (byp_hit !== 1'b1 || byp_data !== 3'b110) begin
         fails++;
         $display("FAIL byp_m_prio: hit=%b data=%b, required 1 110", byp_hit, byp_data);
      end
`else
      if (byp_hit !== 1'b0 || byp_data !== 3'b000) begin
         fails++;
         $display("FAIL byp_off: hit=%b data=%b, required 0 000", byp_hit, byp_data);
      end
`endif
      tick();
      tests++;
`ifdef EXU_REGWB_BYPASS_EN
      if (byp_hit !== 1'b1 || byp_data !== 3'b110) begin
         fails++;
         $display("FAIL byp_w_only: hit=%b data=%b, required 1 110", byp_hit, byp_data);
      end
`else
      if (byp_hit !== 1'b0) begin
         fails++;
         $display("FAIL byp_off_w: hit=%b, required 0", byp_hit);
      end
`endif
      thr_out = 4'b0000;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         write_e(4'b0010, 3'($urandom_range(0, 7)), 1);
         tick();
      end
      idle_e();
      tick();
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL b2b_drain: %0d writes outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_illegal();
      tests++;
      if (err_thr !== 1'b0) begin
         fails++;
         $display("FAIL illegal_pre: err_thr=%b, required 0", err_thr);
      end
      write_e(4'b0011, 3'b100, 0);
      tick();
      idle_e();
      #1;
      tests++;
      if (err_thr !== 1'b1 || pend !== 4'b0000) begin
         fails++;
         $display("FAIL illegal_set: err_thr=%b pend=%b, required 1 0000", err_thr, pend);
      end
      tick();
      tick();
      tick();
      tests++;
      if (err_thr !== 1'b1 || wen_w !== 1'b0) begin
         fails++;
         $display("FAIL illegal_sticky: err_thr=%b wen_w=%b, required 1 0", err_thr, wen_w);
      end
   endtask

   task automatic test_reset_midflight();
      write_e(4'b0001, 3'b011, 0);
      tick();
      write_e(4'b0100, 3'b110, 0);
      tick();
      idle_e();
      rst = 1'b1;
      #1;
      tests++;
      if ({wen_w, thr_w, data_in_w, pend, byp_hit, byp_data, err_thr} !== 17'b0) begin
         fails++;
         $display("FAIL rst_mid: got %b, required all zero",
                  {wen_w, thr_w, data_in_w, pend, byp_hit, byp_data, err_thr});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (wen_w !== 1'b0 || pend !== 4'b0000) begin
            fails++;
            $display("FAIL rst_after%0d: wen_w=%b pend=%b, required 0 0000", i, wen_w, pend);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_kill();
      test_stall();
      test_bypass();
      test_back_to_back();
      test_illegal();
      test_reset_midflight();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL final_drain: %0d writes outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
